// File: rtl/ig_pkg.sv
// Shared types and helpers for the image-gradient sequencer.
// Gradients are two signed GW-bit components packed as {Gx,Gy}.
package ig_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_C,
    RD_R,
    RD_D,
    CAP,
    FIN
  } state_t;

  localparam int PW = 8;
  localparam int GW = 10;

  // Zero-extending both operands keeps the difference exact in -255..+255.
  function automatic logic [2*GW-1:0] pack_grad(input logic [PW-1:0] cur,
                                                input logic [PW-1:0] right,
                                                input logic [PW-1:0] down);
    logic [GW-1:0] gx;
    logic [GW-1:0] gy;
    gx = GW'(right) - GW'(cur);
    gy = GW'(down) - GW'(cur);
    return {gx, gy};
  endfunction

endpackage

// File: rtl/ig_if.sv
// Start/done handshake plus image-read and gradient-write ports.
// master = the sequencer, slave = the surrounding system and SRAMs.
interface ig_if
  import ig_pkg::*;
#(
  parameter int AW = 16
);
  logic            start;
  logic            busy;
  logic            done;
  logic            img_rd;
  logic [AW-1:0]   img_addr;
  logic [PW-1:0]   img_di;
  logic            grad_wr;
  logic [AW-1:0]   grad_addr;
  logic [2*GW-1:0] grad_do;

  modport master (
    input  start, img_di,
    output busy, done, img_rd, img_addr, grad_wr, grad_addr, grad_do
  );

  modport slave (
    output start, img_di,
    input  busy, done, img_rd, img_addr, grad_wr, grad_addr, grad_do
  );
endinterface

// File: rtl/ig_raster_cnt.sv
// Row/column raster counter covering col 0..W-2, row 0..H-2.
// Flags mark the last centre column and last centre row.
module ig_raster_cnt #(
  parameter int W  = 256,
  parameter int H  = 256,
  parameter int CW = $clog2(W),
  parameter int RW = $clog2(H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clr,
  input  logic          i_adv,
  output logic [RW-1:0] o_row,
  output logic [CW-1:0] o_col,
  output logic          o_last_col,
  output logic          o_last_row
);

  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;

  assign o_row      = r_row;
  assign o_col      = r_col;
  assign o_last_col = (r_col == CW'(W - 2));
  assign o_last_row = (r_row == RW'(H - 2));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_clr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_adv) begin
      if (o_last_col) begin
        r_col <= '0;
        r_row <= o_last_row ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ig_ctrl.sv
// Image-gradient sequencer: three cycles per pixel, right neighbour reused
// as the next centre, {Gx,Gy} written for every pixel except last row/col.
module ig_ctrl
  import ig_pkg::*;
#(
  parameter int W  = 256,
  parameter int H  = 256,
  parameter int AW = 16
) (
  input logic  clk,
  input logic  reset,
  ig_if.master bus
);

  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);

  state_t          r_state;
  state_t          w_next;
  logic            r_busy;
  logic            r_done;
  logic            r_img_rd;
  logic [AW-1:0]   r_img_addr;
  logic            r_grad_wr;
  logic [AW-1:0]   r_grad_addr;
  logic [2*GW-1:0] r_grad_do;
  logic [PW-1:0]   r_cur;
  logic [PW-1:0]   r_right;

  logic            w_clr;
  logic            w_adv;
  logic            w_rd_nxt;
  logic [AW-1:0]   w_addr_nxt;
  logic [RW-1:0]   w_row;
  logic [CW-1:0]   w_col;
  logic            w_last_col;
  logic            w_last_row;
  logic [AW-1:0]   w_base;

  ig_raster_cnt #(
    .W  (W),
    .H  (H),
    .CW (CW),
    .RW (RW)
  ) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (w_clr),
    .i_adv      (w_adv),
    .o_row      (w_row),
    .o_col      (w_col),
    .o_last_col (w_last_col),
    .o_last_row (w_last_row)
  );

  assign w_base = {w_row, w_col};

  // Read addresses are registered, so each is formed from the current
  // centre plus the offset of the read issued in the next state.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next     = r_state;
    w_clr      = 1'b0;
    w_adv      = 1'b0;
    w_rd_nxt   = 1'b0;
    w_addr_nxt = r_img_addr;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_next     = RD_C;
          w_clr      = 1'b1;
          w_rd_nxt   = 1'b1;
          w_addr_nxt = '0;
        end
      end
      RD_C: begin
        w_next     = RD_R;
        w_rd_nxt   = 1'b1;
        w_addr_nxt = w_base + AW'(1);
      end
      RD_R: begin
        w_next     = RD_D;
        w_rd_nxt   = 1'b1;
        w_addr_nxt = w_base + AW'(W);
      end
      RD_D: w_next = CAP;
      CAP: begin
        w_adv = 1'b1;
        // At the last column base+2 is exactly {row+1,0}.
        if (!w_last_col) begin
          w_next     = RD_R;
          w_rd_nxt   = 1'b1;
          w_addr_nxt = w_base + AW'(2);
        end else if (!w_last_row) begin
          w_next     = RD_C;
          w_rd_nxt   = 1'b1;
          w_addr_nxt = w_base + AW'(2);
        end else begin
          w_next = FIN;
        end
      end
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_img_rd    <= 1'b0;
      r_img_addr  <= '0;
      r_grad_wr   <= 1'b0;
      r_grad_addr <= '0;
      r_grad_do   <= '0;
      r_cur       <= '0;
      r_right     <= '0;
    end else begin
      r_state   <= w_next;
      r_busy    <= (w_next inside {RD_C, RD_R, RD_D, CAP});
      r_done    <= (r_state == FIN);
      r_img_rd  <= w_rd_nxt;
      r_img_addr <= w_addr_nxt;
      r_grad_wr <= (r_state == CAP);
      // RD_R at column 0 can only follow RD_C, so this is the row's first centre.
      if (r_state == RD_R && w_col == '0) r_cur <= bus.img_di;
      if (r_state == RD_D) r_right <= bus.img_di;
      if (r_state == CAP) begin
        r_grad_do   <= pack_grad(r_cur, r_right, bus.img_di);
        r_grad_addr <= w_base;
        r_cur       <= r_right;
      end
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.img_rd    = r_img_rd;
  assign bus.img_addr  = r_img_addr;
  assign bus.grad_wr   = r_grad_wr;
  assign bus.grad_addr = r_grad_addr;
  assign bus.grad_do   = r_grad_do;

endmodule

// File: tb/tb_ig_ctrl.sv
// Scoreboard bench for ig_ctrl on a 16x8 image: expected gradient writes are
// queued from a pixel-level model at start, a negedge monitor pops and compares.
module tb_ig_ctrl;

  localparam int W   = 16;
  localparam int H   = 8;
  localparam int AW  = 7;
  localparam int LAT = (H - 1) * (1 + 3 * (W - 1));

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [19:0]   data;
  } wr_t;

  logic clk = 1'b0;
  logic reset;

  ig_if #(.AW(AW)) bus ();

  ig_ctrl #(.W(W), .H(H), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [W*H];
  wr_t         exp_q [$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_wr = 0;
  int          n_done = 0;
  int          t_wr = 0;
  int          t_done = 0;
  int          t_busy = 0;
  int          frame_w0 = 0;
  logic [19:0] first_data;
  logic        prev_rd = 1'b0;
  logic        prev_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Image SRAM: synchronous read, data valid the cycle after the strobe.
  always @(posedge clk) if (bus.img_rd) bus.img_di <= mem[bus.img_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: gradients straight from the pixel array.
  task automatic push_frame();
    for (int r = 0; r < H - 1; r++) begin
      for (int c = 0; c < W - 1; c++) begin
        int p  = mem[r*W + c];
        int gx = int'(mem[r*W + c + 1]) - p;
        int gy = int'(mem[(r+1)*W + c]) - p;
        wr_t e;
        e.addr = AW'(r*W + c);
        e.data = {gx[9:0], gy[9:0]};
        exp_q.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      prev_rd   = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (bus.grad_wr) begin
        wr_t e;
        if (n_wr == frame_w0) first_data = bus.grad_do;
        check("rd_in_cap", prev_rd, 0);
        check("wr_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("wr_addr", bus.grad_addr, e.addr);
          check("wr_data", bus.grad_do, e.data);
        end
        t_wr = cyc;
        n_wr++;
      end
      if (bus.img_rd) check("rd_while_busy", bus.busy, 1);
      if (bus.done) begin
        t_done = cyc;
        n_done++;
      end
      if (bus.busy && !prev_busy) t_busy = cyc;
      prev_rd   = bus.img_rd;
      prev_busy = bus.busy;
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},      bus.busy, 0);
    check({tag, "_done"},      bus.done, 0);
    check({tag, "_img_rd"},    bus.img_rd, 0);
    check({tag, "_img_addr"},  bus.img_addr, 0);
    check({tag, "_grad_wr"},   bus.grad_wr, 0);
    check({tag, "_grad_addr"}, bus.grad_addr, 0);
    check({tag, "_grad_do"},   bus.grad_do, 0);
  endtask

  task automatic run_frame(input bit hold);
    int d0, w0, s;
    d0 = n_done;
    w0 = n_wr;
    frame_w0 = n_wr;
    push_frame();
    @(posedge clk); #1;
    bus.start = 1'b1;
    s = cyc;
    if (!hold) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    for (int t = 0; t < LAT + 40 && n_done == d0; t++) begin
      @(negedge clk); #1;
    end
    bus.start = 1'b0;
    check("frame_done", n_done - d0, 1);
    check("busy_rise", t_busy, s + 1);
    check("latency", t_wr - t_busy, LAT);
    check("done_gap", t_done, t_wr + 1);
    check("wr_count", n_wr - w0, (W - 1) * (H - 1));
    check("q_empty", exp_q.size(), 0);
    exp_q.delete();
    repeat (20) @(negedge clk);
    #1;
    check("one_done", n_done - d0, 1);
    check("idle_busy", bus.busy, 0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < W*H; i++) mem[i] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, w0;
    reset     = 1'b0;
    bus.start = 1'b0;
    #12;
    check_outputs_zero("rst");
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Ramp image: Gx=1, Gy=W everywhere.
    for (int i = 0; i < W*H; i++) mem[i] = 8'(i);
    run_frame(1'b0);
    check("ramp_first", first_data, {10'd1, 10'd16});

    // Largest negative step at pixel 0 (-255 is 10'h301).
    for (int i = 0; i < W*H; i++) mem[i] = 8'd0;
    mem[0] = 8'd255;
    run_frame(1'b0);
    check("neg_first", first_data, 20'hC0701);

    // start held through the whole frame and the FIN cycle.
    fill_random();
    run_frame(1'b1);

    // Reset mid-frame after five writes.
    fill_random();
    push_frame();
    w0 = n_wr;
    d0 = n_done;
    frame_w0 = n_wr;
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int t = 0; t < LAT && n_wr - w0 < 5; t++) begin
      @(negedge clk); #1;
    end
    check("rst_pre_wr", n_wr - w0, 5);
    reset = 1'b0;
    #1;
    check_outputs_zero("mid_rst");
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (60) @(negedge clk);
    #1;
    check("rst_no_wr", n_wr - w0, 5);
    check("rst_no_done", n_done - d0, 0);
    check("rst_idle", bus.busy, 0);

    // Random images, restarting cleanly from pixel 0.
    for (int k = 0; k < 2; k++) begin
      fill_random();
      run_frame(1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
